// File: rtl/stack_pkg.sv
// Shared definitions for the stack engine: opcodes, FSM state encoding and
// the word-size helper used by the top and the RAM.
package stack_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WRITE_TOP = 3'd1;
  localparam logic [2:0] OP_PUSH      = 3'd2;
  localparam logic [2:0] OP_POP       = 3'd3;
  localparam logic [2:0] OP_READ      = 3'd4;
  localparam logic [2:0] OP_WRITE     = 3'd5;
  localparam logic [2:0] OP_SET_ESP   = 3'd6;
  localparam logic [2:0] OP_CLEAR     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_CLEARING = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  // Number of bytes in one data word.
  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Command/response bus between the execute stage (master) and the stack
// engine (slave).
//
// Handshake: a command transfers on a rising clock edge where op_valid and
// op_ready are both high; op_code/op_addr/op_data are sampled on that edge.
// A response is offered while rsp_valid is high, with rsp_data/rsp_fault
// held stable until the edge where rsp_valid and rsp_ready are both high.
interface stack_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_fault;

  modport master (
    output op_valid, op_code, op_addr, op_data, rsp_ready,
    input  op_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  op_valid, op_code, op_addr, op_data, rsp_ready,
    output op_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/stack_ram.sv
// Byte-organised stack RAM: synchronous word write and combinational
// little-endian word read window at any byte address. Lanes that fall past
// the end of the array are dropped on write and read back as zero.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 512,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int BYTES = bytes_of(DATA_W);
  localparam int IW    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH_BYTES);

  logic [7:0]      mem [DEPTH_BYTES];
  logic [ADDR_W:0] lane_x [BYTES];
  logic [BYTES-1:0] lane_ok;

  // Byte address of each lane, widened so the range test cannot wrap.
  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      lane_x[i]  = {1'b0, addr} + (ADDR_W+1)'(i);
      lane_ok[i] = lane_x[i] < DEPTH_X;
    end
  end

  // Little-endian read window: byte at addr lands in the LSB lane.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (lane_ok[i]) rdata[8*i +: 8] = mem[lane_x[i][IW-1:0]];
    end
  end

  // Word write, one byte per lane.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (lane_ok[i]) mem[lane_x[i][IW-1:0]] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/stack_unit.sv
// Stack engine: owns esp and the stack RAM, executes push/pop/random-access
// commands over a valid/ready bus, reports faults and runs a word-by-word
// zero fill for CLEAR.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 512,
  parameter int ADDR_W      = 32,
  parameter int ESP_INIT    = DEPTH_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  stack_unit_if.slave       bus,
  output logic [ADDR_W-1:0] esp,
  output logic              fault,
  output logic              empty,
  output logic              full,
  output state_e            state_dbg
);
  localparam int BYTES = bytes_of(DATA_W);
  localparam int WORDS = DEPTH_BYTES / BYTES;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0]   BYTES_X = (ADDR_W+1)'(BYTES);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   INIT_X  = (ADDR_W+1)'(ESP_INIT);
  localparam logic [ADDR_W-1:0] ESP_RST = ADDR_W'(ESP_INIT);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] esp_q, esp_d;
  logic              fault_q, fault_d;
  logic [2:0]        code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [CW-1:0]     clr_idx_q, clr_idx_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [ADDR_W:0]   e_x, a_x;
  logic              top_in_range, addr_in_range, op_fault;
  logic [ADDR_W-1:0] push_addr;

  stack_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, esp/fault update and RAM port control for every state.
  always_comb begin
    state_d     = state_q;
    esp_d       = esp_q;
    fault_d     = fault_q;
    code_d      = code_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    clr_idx_d   = clr_idx_q;
    ram_we      = 1'b0;
    ram_addr    = esp_q;
    ram_wdata   = data_q;
    op_fault    = 1'b0;

    // Range tests are done one bit wider than the address so they never wrap.
    e_x           = {1'b0, esp_q};
    a_x           = {1'b0, addr_q};
    top_in_range  = (e_x + BYTES_X) <= DEPTH_X;
    addr_in_range = (a_x + BYTES_X) <= DEPTH_X;
    push_addr     = esp_q - BYTES_A;

    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          code_d    = bus.op_code;
          addr_d    = bus.op_addr;
          data_d    = bus.op_data;
          clr_idx_d = '0;
          state_d   = (bus.op_code == OP_CLEAR) ? ST_CLEARING : ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        rsp_data_d = '0;
        case (code_q)
          OP_WRITE_TOP: begin
            if (!top_in_range) op_fault = 1'b1;
            else               ram_we   = 1'b1;
          end
          OP_PUSH: begin
            if (e_x < BYTES_X) begin
              op_fault = 1'b1;
            end else begin
              esp_d    = push_addr;
              ram_addr = push_addr;
              ram_we   = 1'b1;
            end
          end
          OP_POP: begin
            if ((e_x + BYTES_X) > INIT_X) begin
              op_fault = 1'b1;
            end else begin
              rsp_data_d = ram_rdata;
              esp_d      = esp_q + BYTES_A;
            end
          end
          OP_READ: begin
            ram_addr = addr_q;
            if (!addr_in_range) op_fault   = 1'b1;
            else                rsp_data_d = ram_rdata;
          end
          OP_WRITE: begin
            ram_addr = addr_q;
            if (!addr_in_range) op_fault = 1'b1;
            else                ram_we   = 1'b1;
          end
          OP_SET_ESP: begin
            if (a_x > INIT_X) op_fault = 1'b1;
            else              esp_d    = addr_q;
          end
          default: ;
        endcase
        rsp_fault_d = op_fault;
        if (op_fault) begin
          rsp_data_d = '0;
          fault_d    = 1'b1;
        end
        state_d = ST_RESP;
      end

      ST_CLEARING: begin
        ram_we    = 1'b1;
        ram_addr  = ADDR_W'(clr_idx_q) * BYTES_A;
        ram_wdata = '0;
        if (clr_idx_q == CW'(WORDS - 1)) begin
          esp_d       = ESP_RST;
          fault_d     = 1'b0;
          rsp_data_d  = '0;
          rsp_fault_d = 1'b0;
          state_d     = ST_RESP;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A reset edge aborts whatever was in flight, including the write.
    if (!reset) ram_we = 1'b0;
  end

  // State registers; RAM contents are deliberately not touched by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      esp_q       <= ESP_RST;
      fault_q     <= 1'b0;
      code_q      <= OP_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      clr_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      esp_q       <= esp_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

  assign bus.op_ready  = (state_q == ST_IDLE) && reset;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign esp           = esp_q;
  assign fault         = fault_q;
  assign empty         = (esp_q == ESP_RST);
  assign full          = ({1'b0, esp_q} < BYTES_X);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios plus a randomized command stream,
// all checked against a byte-array reference model of the stack.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int     DATA_W = 32;
  localparam int     ADDR_W = 32;
  localparam int     DEPTH  = 512;
  localparam int     BYTES  = 4;
  localparam int     WORDS  = DEPTH / BYTES;
  localparam longint INIT   = 512;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [ADDR_W-1:0] esp;
  logic              fault, empty, full;
  state_e            state_dbg;

  stack_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  stack_unit #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH),
    .ADDR_W      (ADDR_W),
    .ESP_INIT    (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .esp       (esp),
    .fault     (fault),
    .empty     (empty),
    .full      (full),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int              tests_run    = 0;
  int              tests_failed = 0;
  logic [DATA_W-1:0] exp_q[$];

  logic [7:0]  m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_esp;
  bit          m_fault;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one command to the model; returns the expected response.
  task automatic model_op(input logic [2:0] code, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rd, output bit flt, output bit known);
    longint e;
    longint a;
    longint wa;
    longint ra;
    bit     do_wr;
    bit     do_rd;
    e = m_esp; a = addr; wa = 0; ra = 0; do_wr = 0; do_rd = 0;
    rd = '0; flt = 0; known = 1;
    case (code)
      OP_WRITE_TOP: if (e + BYTES > DEPTH) flt = 1; else begin do_wr = 1; wa = e; end
      OP_PUSH:      if (e < BYTES) flt = 1; else begin do_wr = 1; wa = e - BYTES; m_esp = 32'(e - BYTES); end
      OP_POP:       if (e + BYTES > INIT) flt = 1; else begin do_rd = 1; ra = e; m_esp = 32'(e + BYTES); end
      OP_READ:      if (a + BYTES > DEPTH) flt = 1; else begin do_rd = 1; ra = a; end
      OP_WRITE:     if (a + BYTES > DEPTH) flt = 1; else begin do_wr = 1; wa = a; end
      OP_SET_ESP:   if (a > INIT) flt = 1; else m_esp = addr;
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_known[i] = 1; end
        m_esp = 32'(INIT); m_fault = 0;
      end
      default: ;
    endcase
    if (do_wr) for (int i = 0; i < BYTES; i++) begin
      m_mem[int'(wa) + i] = data[8*i +: 8]; m_known[int'(wa) + i] = 1;
    end
    if (do_rd) for (int i = 0; i < BYTES; i++) begin
      rd[8*i +: 8] = m_mem[int'(ra) + i];
      if (!m_known[int'(ra) + i]) known = 0;
    end
    if (flt) m_fault = 1;
  endtask

  // ---------------- driver ----------------
  // Issue one command, wait for its response, check it, optionally stall
  // the response for `hold` cycles (with an ignored op_valid pulse), then
  // accept it.
  task automatic do_op(input logic [2:0] code, input logic [31:0] addr, input logic [31:0] data,
                       input int hold, input string tag);
    logic [31:0] exp_data;
    logic [31:0] exp_d;
    bit          exp_fault;
    bit          known;
    int          lat;
    int          exp_lat;
    model_op(code, addr, data, exp_data, exp_fault, known);
    exp_q.push_back(exp_data);
    exp_lat = (code == OP_CLEAR) ? WORDS + 1 : 2;

    @(negedge clock);
    check({tag, "/op_ready"}, bus.op_ready, 1);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_addr = addr; bus.op_data = data;
    @(posedge clock); #1;
    bus.op_valid = 1'b0; bus.op_code = 3'($urandom); bus.op_addr = $urandom; bus.op_data = $urandom;

    lat = 0;
    while (lat < 300) begin
      @(negedge clock); lat++;
      if (bus.rsp_valid) break;
    end
    check({tag, "/latency"}, lat, exp_lat);
    exp_d = exp_q.pop_front();
    if (!bus.rsp_valid) return;

    if (known) check({tag, "/rsp_data"}, bus.rsp_data, exp_d);
    check({tag, "/rsp_fault"}, bus.rsp_fault, exp_fault);
    check({tag, "/esp"},       esp,   m_esp);
    check({tag, "/fault"},     fault, m_fault);
    check({tag, "/empty"},     empty, m_esp == 32'(INIT));
    check({tag, "/full"},      full,  m_esp < BYTES);

    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        bus.op_valid = 1'b1; bus.op_code = OP_PUSH; bus.op_data = 32'hDEAD_BEEF;
      end
      @(negedge clock);
      bus.op_valid = 1'b0;
      check({tag, "/hold_valid"}, bus.rsp_valid, 1);
      check({tag, "/hold_ready"}, bus.op_ready, 0);
      check({tag, "/hold_fault"}, bus.rsp_fault, exp_fault);
      if (known) check({tag, "/hold_data"}, bus.rsp_data, exp_d);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    check({tag, "/rsp_done"}, bus.rsp_valid, 0);
    check({tag, "/esp_after"}, esp, m_esp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  code;
    logic [31:0] addr;
    int          sel;

    bus.op_valid = 1'b0; bus.op_code = OP_NOP; bus.op_addr = '0; bus.op_data = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_known[i] = 0; end
    m_esp = 32'(INIT); m_fault = 0;

    // 1. reset
    repeat (3) @(negedge clock);
    check("rst/op_ready_low", bus.op_ready, 0);
    check("rst/rsp_valid_low", bus.rsp_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rst/esp",       esp, 32'h200);
    check("rst/empty",     empty, 1);
    check("rst/full",      full, 0);
    check("rst/op_ready",  bus.op_ready, 1);
    check("rst/rsp_valid", bus.rsp_valid, 0);
    check("rst/rsp_data",  bus.rsp_data, 0);
    check("rst/rsp_fault", bus.rsp_fault, 0);
    check("rst/fault",     fault, 0);
    check("rst/state",     state_dbg, ST_IDLE);

    // 2. ordered push / read / pop
    do_op(OP_PUSH, 0, 32'hAABBCCDD, 0, "push1");
    check("push1/esp_const", esp, 32'h1FC);
    do_op(OP_PUSH, 0, 32'h11223344, 0, "push2");
    check("push2/esp_const", esp, 32'h1F8);
    do_op(OP_READ, 32'h1F9, 0, 0, "read_1f9");
    do_op(OP_POP, 0, 0, 0, "pop1");
    check("pop1/esp_const", esp, 32'h1FC);
    do_op(OP_POP, 0, 0, 0, "pop2");

    // 3. underflow, sticky fault
    do_op(OP_POP, 0, 0, 0, "underflow");
    check("underflow/fault_const", fault, 1);
    do_op(OP_PUSH, 0, 32'h5, 0, "push_after_fault");
    do_op(OP_POP, 0, 0, 0, "pop5");

    // 4. overflow and range boundaries
    do_op(OP_SET_ESP, 32'h4, 0, 0, "set_esp4");
    do_op(OP_PUSH, 0, 32'h1, 0, "push_to_0");
    check("push_to_0/full_const", full, 1);
    do_op(OP_PUSH, 0, 32'h2, 0, "overflow");
    do_op(OP_WRITE_TOP, 0, 32'h0BAD_F00D, 0, "write_top_0");
    do_op(OP_READ, 32'h0, 0, 0, "read_0");
    do_op(OP_READ, 32'h1FE, 0, 0, "read_1fe");
    do_op(OP_WRITE, 32'h1FC, 32'hCAFE_0001, 0, "write_1fc");
    do_op(OP_READ, 32'h1FD, 0, 0, "read_1fd");
    do_op(OP_SET_ESP, 32'h201, 0, 0, "set_esp_201");
    do_op(OP_SET_ESP, 32'h200, 0, 0, "set_esp_200");
    do_op(OP_WRITE_TOP, 0, 32'h1234_5678, 0, "write_top_200");
    do_op(OP_NOP, 32'h55, 32'h66, 0, "nop");

    // 5. response back-pressure
    do_op(OP_READ, 32'h1FC, 0, 5, "hold_read");
    do_op(OP_POP, 0, 0, 5, "hold_fault");

    // 6a. fill, set fault, full CLEAR
    for (int w = 0; w < WORDS; w++) do_op(OP_WRITE, 32'(w * BYTES), $urandom, 0, "fill");
    do_op(OP_POP, 0, 0, 0, "fault_before_clear");
    do_op(OP_CLEAR, 0, 0, 0, "clear");
    do_op(OP_READ, 32'h100, 0, 0, "read_100_cleared");
    do_op(OP_READ, 32'h1FC, 0, 0, "read_1fc_cleared");

    // randomized command stream
    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, 99);
      addr = $urandom_range(0, 32'h203);
      if      (sel < 30) code = OP_PUSH;
      else if (sel < 55) code = OP_POP;
      else if (sel < 67) code = OP_READ;
      else if (sel < 77) code = OP_WRITE;
      else if (sel < 84) code = OP_WRITE_TOP;
      else if (sel < 95) begin
        code = OP_SET_ESP;
        addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(32'h1E0, 32'h202);
      end
      else code = OP_NOP;
      do_op(code, addr, $urandom, $urandom_range(0, 2), "rand");
    end

    // 6b. reset during CLEAR
    do_op(OP_WRITE, 32'h0,   32'h0101_0101, 0, "pre_w0");
    do_op(OP_WRITE, 32'h9C,  32'h3939_3939, 0, "pre_w39");
    do_op(OP_WRITE, 32'hA4,  32'h4141_4141, 0, "pre_w41");
    do_op(OP_WRITE, 32'h1FC, 32'h7F7F_7F7F, 0, "pre_w127");
    do_op(OP_SET_ESP, 32'h200, 0, 0, "pre_set");
    do_op(OP_POP, 0, 0, 0, "pre_fault");

    @(negedge clock);
    check("abort/op_ready", bus.op_ready, 1);
    bus.op_valid = 1'b1; bus.op_code = OP_CLEAR;
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    // Words 0..39 were zeroed before the abort; word 40 is left unspecified.
    for (int i = 0; i < 40 * BYTES; i++) begin m_mem[i] = 8'h00; m_known[i] = 1; end
    for (int i = 40 * BYTES; i < 41 * BYTES; i++) m_known[i] = 0;
    m_esp = 32'(INIT); m_fault = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("abort/no_rsp", bus.rsp_valid, 0);
      check("abort/idle", state_dbg, ST_IDLE);
    end
    check("abort/esp",   esp, 32'h200);
    check("abort/fault", fault, 0);
    do_op(OP_READ, 32'h0,   0, 0, "abort_read_w0");
    do_op(OP_READ, 32'h9C,  0, 0, "abort_read_w39");
    do_op(OP_READ, 32'hA4,  0, 0, "abort_read_w41");
    do_op(OP_READ, 32'h1FC, 0, 0, "abort_read_w127");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
